if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 5-stage pipeline. It owns the program counter, issues instruction reads on the instruction bus, tolerates bus wait states, and applies branch redirects and exception flushes. It presents fetched `{pc, inst}` to the IF/ID pipeline register. It raises a stall request to the pipeline controller while no instruction is available.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first fetch address after reset.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 6: controller stall vector. `stall[0]` holds PC; `stall[1]` holds IF/ID (downstream not accepting); `stall[2]` holds ID.
- `flush_i` in 1: exception flush.
- `new_pc_i` in 32: exception target, used with `flush_i`.
- `branch_flag_i` in 1: taken branch resolved in ID.
- `branch_target_i` in 32: branch target.
- `ibus_req_o` out 1: fetch request.
- `ibus_addr_o` out 32: fetch address.
- `ibus_ack_i` in 1: single-cycle acknowledge; may be high in the first cycle `req` is high (zero-wait).
- `ibus_rdata_i` in 32: instruction word, valid only when `ack` is high.
- `if_pc_o` out 32: PC of the presented instruction.
- `if_inst_o` out 32: presented instruction, or `32'h0` when none is available.
- `stallreq_o` out 1: no instruction available this cycle.

## Operation
- Registers:
  - `pc`: current fetch address.
  - `state`: FETCH, HOLD or DROP.
  - `buf_inst` / `buf_valid`: held instruction.
  - `drop_addr`: address of the abandoned request.
  - `br_pend` / `br_tgt`: deferred branch.
- `avail` = (state==FETCH && `ibus_ack_i`) || (state==HOLD).
  - Presented word is `ibus_rdata_i` in FETCH and `buf_inst` in HOLD.
- `stallreq_o` = !`avail` && !`flush_i`.
  - Must not depend on `stall` (this avoids a combinational loop through the controller).
- `if_pc_o` = `pc`. `if_inst_o` = presented word if `avail`, else 0.
- FETCH: `ibus_req_o`=1, `ibus_addr_o`=`pc`.
  - No ack: stay in FETCH, `pc` unchanged, address held stable.
  - Ack with `stall[1]`=1: capture `ibus_rdata_i` into `buf_inst`, set `buf_valid`, go to HOLD.
  - Ack with `stall[1]`=0 (accepted): `pc` ← next PC, stay in FETCH.
- HOLD: `ibus_req_o`=0.
  - When `stall[1]`=0: accepted, `pc` ← next PC, clear `buf_valid`, go to FETCH.
- DROP: `ibus_req_o`=1, `ibus_addr_o`=`drop_addr`, data ignored.
  - On ack: go to FETCH. `pc` already holds the new target.
- Next PC selection, in priority order:
  1. `branch_target_i` if `branch_flag_i` && !`stall[2]` in the accept cycle.
  2. `br_tgt` if `br_pend`.
  3. `pc`+4, modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
  - `br_pend` is cleared on use.
- Branch capture: `branch_flag_i` && !`stall[2]` in a non-accept cycle sets `br_pend`, `br_tgt` ← `branch_target_i`.
  - The instruction in flight is the delay slot and is never discarded by a branch.
- Flush has top priority over everything above:
  - Clears `buf_valid` and `br_pend`; `pc` ← `new_pc_i`.
  - FETCH without ack: `drop_addr` ← old `pc`, go to DROP.
  - FETCH with ack, or HOLD: go to FETCH; the data is discarded.
  - DROP: stay in DROP.
- `stall[0]` without `stall[1]` never occurs; it is not separately handled.

## Timing
- While `rst`=1, outputs are forced combinationally:
  - `ibus_req_o`=0, `ibus_addr_o`=0.
  - `if_pc_o`=0, `if_inst_o`=0, `stallreq_o`=0.
- On the reset edge: `pc`←`RESET_PC`, state←FETCH, `buf_valid`=0, `br_pend`=0.
- First request is issued in the first cycle after `rst` falls.
- Reset mid-request abandons the request; no drop is performed.
- Zero-wait bus, no stalls: one instruction per cycle; `ibus_addr_o` advances by 4 each cycle.
- N wait states: `stallreq_o`=1 for N cycles, then the word is presented in the ack cycle.
- Latency from bus ack to `if_inst_o`: 0 cycles (combinational). The IF/ID register adds the next edge.
- Flush: the first fetch at `new_pc_i` is issued on the next cycle, or one cycle after the pending drop ack.
- Ack with `stall[1]`=1 and `flush_i`=1 in the same cycle: flush wins; nothing is buffered.

## Test plan
- Reset release, zero-wait bus with ack tied high: addresses `BFC0_0000`, `_0004`, `_0008` on consecutive cycles; `stallreq_o`=0 throughout.
- Ack delayed 2 cycles on `0x100`: `stallreq_o`=1 for 2 cycles, address held at `0x100`; then `if_inst_o`=`rdata`, next address `0x104`.
- Ack at `0x200` with `stall[1]`=1 for 3 cycles: `req`=0, `if_inst_o` holds the captured word all 3 cycles; after release, next request is `0x204`.
- Branch to `0x400` while fetching delay slot `0x204` (ack late): `0x204` is delivered, then the next request is `0x400`.
- `flush_i` with `new_pc_i`=`0x180` while request `0x300` is unacked: `req` stays at `0x300` until ack; that word never appears; then a request at `0x180`.
- PC wrap: `pc`=`FFFF_FFFC`, accepted fetch → next request at `0x0000_0000`.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues instruction-bus reads, absorbs
// bus wait states, and applies branch redirects and exception flushes. The
// fetched {pc, inst} pair goes to the IF/ID register. A stall request is raised
// whenever no instruction can be presented this cycle.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] buf_inst_reg;
    logic        buf_valid_reg;
    logic [31:0] drop_addr_reg;
    logic        br_pend_reg;
    logic [31:0] br_tgt_reg;

    logic        avail;
    logic [31:0] word;
    logic        accept;
    logic        br_now;
    logic [31:0] pc_next;

    // stall[0] always accompanies stall[1]; the higher bits belong to later stages
    logic unused_stall;
    assign unused_stall = &{1'b0, stall[5:3], stall[0]};

    // Availability, presented word, accept condition and next-PC selection
    always_comb begin
        avail   = (state_reg == FETCH && ibus_ack_i) || (state_reg == HOLD && buf_valid_reg);
        word    = (state_reg == HOLD) ? buf_inst_reg : ibus_rdata_i;
        accept  = ((state_reg == FETCH && ibus_ack_i) || state_reg == HOLD) && !stall[1];
        br_now  = branch_flag_i && !stall[2];
        if (br_now) begin
            pc_next = branch_target_i;
        end else if (br_pend_reg) begin
            pc_next = br_tgt_reg;
        end else begin
            pc_next = pc_reg + 32'd4;
        end
    end

    // Output drive; everything is forced quiet while reset is asserted
    always_comb begin
        ibus_req_o  = 1'b0;
        ibus_addr_o = 32'h0;
        if_pc_o     = 32'h0;
        if_inst_o   = 32'h0;
        stallreq_o  = 1'b0;
        if (!rst) begin
            ibus_req_o  = (state_reg != HOLD);
            ibus_addr_o = (state_reg == DROP) ? drop_addr_reg : pc_reg;
            if_pc_o     = pc_reg;
            if_inst_o   = avail ? word : 32'h0;
            stallreq_o  = !avail && !flush_i;
        end
    end

    // Fetch state machine: flush overrides everything, then normal fetch flow
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            buf_inst_reg  <= 32'h0;
            buf_valid_reg <= 1'b0;
            drop_addr_reg <= 32'h0;
            br_pend_reg   <= 1'b0;
            br_tgt_reg    <= 32'h0;
        end else if (flush_i) begin
            buf_valid_reg <= 1'b0;
            br_pend_reg   <= 1'b0;
            pc_reg        <= new_pc_i;
            case (state_reg)
                FETCH: begin
                    // An unacked request cannot be withdrawn; remember it and drain it
                    if (!ibus_ack_i) begin
                        drop_addr_reg <= pc_reg;
                        state_reg     <= DROP;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                HOLD:    state_reg <= FETCH;
                default: state_reg <= DROP;
            endcase
        end else begin
            case (state_reg)
                FETCH: begin
                    if (ibus_ack_i && stall[1]) begin
                        buf_inst_reg  <= ibus_rdata_i;
                        buf_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall[1]) begin
                        buf_valid_reg <= 1'b0;
                        state_reg     <= FETCH;
                    end
                end
                default: begin
                    if (ibus_ack_i) begin
                        state_reg <= FETCH;
                    end
                end
            endcase
            // The instruction in flight is the delay slot, so a branch seen
            // before it is accepted is deferred rather than applied
            if (accept) begin
                pc_reg      <= pc_next;
                br_pend_reg <= 1'b0;
            end else if (br_now) begin
                br_pend_reg <= 1'b1;
                br_tgt_reg  <= branch_target_i;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: one task per scenario, inline comparisons.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stallreq_o;

    int checks;
    int errors;

    if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .ibus_req_o      (ibus_req_o),
        .ibus_addr_o     (ibus_addr_o),
        .ibus_ack_i      (ibus_ack_i),
        .ibus_rdata_i    (ibus_rdata_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .stallreq_o      (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Let combinational outputs settle, well away from the clock edge
    task automatic settle();
        #2;
    endtask

    // Advance one clock and print one line for the cycle just completed
    task automatic tick();
        $display("cyc t=%0t req=%0b addr=%08h pc=%08h inst=%08h sreq=%0b ack=%0b flush=%0b br=%0b",
                 $time, ibus_req_o, ibus_addr_o, if_pc_o, if_inst_o, stallreq_o,
                 ibus_ack_i, flush_i, branch_flag_i);
        @(posedge clk);
        #1;
    endtask

    // Redirect via flush while an ack is present so the next cycle fetches at target
    task automatic jump_to(input logic [31:0] target);
        flush_i = 1'b1; new_pc_i = target; ibus_ack_i = 1'b1; stall = 6'b0;
        settle();
        tick();
        flush_i = 1'b0; ibus_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'b0; flush_i = 1'b0; new_pc_i = 32'h0;
        branch_flag_i = 1'b0; branch_target_i = 32'h0;
        ibus_ack_i = 1'b1; ibus_rdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        settle();
        checks++;
        if ({ibus_req_o, ibus_addr_o, if_pc_o, if_inst_o, stallreq_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b addr=%08h pc=%08h inst=%08h sreq=%0b, expected all zero",
                     ibus_req_o, ibus_addr_o, if_pc_o, if_inst_o, stallreq_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr;
        exp_addr = 32'hBFC0_0000;
        ibus_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ibus_rdata_i = 32'hA000_0000 + 32'(i);
            settle();
            checks++;
            if ({ibus_req_o, ibus_addr_o, stallreq_o} !== {1'b1, exp_addr, 1'b0}) begin
                errors++;
                $display("FAIL zero_wait_addr[%0d]: got req=%0b addr=%08h sreq=%0b, expected req=1 addr=%08h sreq=0",
                         i, ibus_req_o, ibus_addr_o, stallreq_o, exp_addr);
            end
            checks++;
            if ({if_pc_o, if_inst_o} !== {exp_addr, 32'hA000_0000 + 32'(i)}) begin
                errors++;
                $display("FAIL zero_wait_data[%0d]: got pc=%08h inst=%08h, expected pc=%08h inst=%08h",
                         i, if_pc_o, if_inst_o, exp_addr, 32'hA000_0000 + 32'(i));
            end
            tick();
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic test_wait_states();
        jump_to(32'h0000_0100);
        ibus_rdata_i = 32'hDEAD_0100;
        for (int i = 0; i < 2; i++) begin
            ibus_ack_i = 1'b0;
            settle();
            checks++;
            if ({ibus_req_o, ibus_addr_o, if_inst_o, stallreq_o} !== {1'b1, 32'h100, 32'h0, 1'b1}) begin
                errors++;
                $display("FAIL wait_state[%0d]: got req=%0b addr=%08h inst=%08h sreq=%0b, expected req=1 addr=00000100 inst=0 sreq=1",
                         i, ibus_req_o, ibus_addr_o, if_inst_o, stallreq_o);
            end
            tick();
        end
        ibus_ack_i = 1'b1;
        settle();
        checks++;
        if ({if_pc_o, if_inst_o, stallreq_o} !== {32'h100, 32'hDEAD_0100, 1'b0}) begin
            errors++;
            $display("FAIL wait_ack: got pc=%08h inst=%08h sreq=%0b, expected pc=00000100 inst=dead0100 sreq=0",
                     if_pc_o, if_inst_o, stallreq_o);
        end
        tick();
        ibus_ack_i = 1'b0;
        settle();
        checks++;
        if (ibus_addr_o !== 32'h104) begin
            errors++;
            $display("FAIL wait_next_addr: got %08h, expected 00000104", ibus_addr_o);
        end
    endtask

    task automatic test_hold();
        jump_to(32'h0000_0200);
        ibus_ack_i = 1'b1; ibus_rdata_i = 32'hCAFE_0200; stall = 6'b000011;
        settle();
        checks++;
        if ({if_inst_o, stallreq_o} !== {32'hCAFE_0200, 1'b0}) begin
            errors++;
            $display("FAIL hold_capture: got inst=%08h sreq=%0b, expected inst=cafe0200 sreq=0",
                     if_inst_o, stallreq_o);
        end
        tick();
        ibus_ack_i = 1'b0; ibus_rdata_i = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            stall = (i == 2) ? 6'b000000 : 6'b000011;
            settle();
            checks++;
            if ({ibus_req_o, if_pc_o, if_inst_o, stallreq_o} !== {1'b0, 32'h200, 32'hCAFE_0200, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle[%0d]: got req=%0b pc=%08h inst=%08h sreq=%0b, expected req=0 pc=00000200 inst=cafe0200 sreq=0",
                         i, ibus_req_o, if_pc_o, if_inst_o, stallreq_o);
            end
            tick();
        end
        stall = 6'b0;
        settle();
        checks++;
        if ({ibus_req_o, ibus_addr_o} !== {1'b1, 32'h204}) begin
            errors++;
            $display("FAIL hold_release: got req=%0b addr=%08h, expected req=1 addr=00000204",
                     ibus_req_o, ibus_addr_o);
        end
    endtask

    task automatic test_branch();
        // Fetching delay slot 0x204 with a wait state while the branch resolves
        ibus_ack_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h400;
        settle();
        checks++;
        if ({ibus_addr_o, stallreq_o} !== {32'h204, 1'b1}) begin
            errors++;
            $display("FAIL branch_wait: got addr=%08h sreq=%0b, expected addr=00000204 sreq=1",
                     ibus_addr_o, stallreq_o);
        end
        tick();
        branch_flag_i = 1'b0; branch_target_i = 32'h0;
        ibus_ack_i = 1'b1; ibus_rdata_i = 32'hB0B0_0204;
        settle();
        checks++;
        if ({if_pc_o, if_inst_o} !== {32'h204, 32'hB0B0_0204}) begin
            errors++;
            $display("FAIL branch_delay_slot: got pc=%08h inst=%08h, expected pc=00000204 inst=b0b00204",
                     if_pc_o, if_inst_o);
        end
        tick();
        settle();
        checks++;
        if (ibus_addr_o !== 32'h400) begin
            errors++;
            $display("FAIL branch_target: got addr=%08h, expected 00000400", ibus_addr_o);
        end
        // Branch resolved in the accept cycle itself redirects immediately
        branch_flag_i = 1'b1; branch_target_i = 32'h800; ibus_rdata_i = 32'h0000_0400;
        settle();
        tick();
        branch_flag_i = 1'b0;
        settle();
        checks++;
        if (ibus_addr_o !== 32'h800) begin
            errors++;
            $display("FAIL branch_direct: got addr=%08h, expected 00000800", ibus_addr_o);
        end
    endtask

    task automatic test_flush_drop();
        jump_to(32'h0000_0300);
        ibus_ack_i = 1'b0; flush_i = 1'b1; new_pc_i = 32'h180;
        settle();
        checks++;
        if ({ibus_addr_o, stallreq_o} !== {32'h300, 1'b0}) begin
            errors++;
            $display("FAIL flush_cycle: got addr=%08h sreq=%0b, expected addr=00000300 sreq=0",
                     ibus_addr_o, stallreq_o);
        end
        tick();
        flush_i = 1'b0; ibus_rdata_i = 32'hBAD0_0300;
        settle();
        checks++;
        if ({ibus_req_o, ibus_addr_o, if_inst_o, stallreq_o} !== {1'b1, 32'h300, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL drop_wait: got req=%0b addr=%08h inst=%08h sreq=%0b, expected req=1 addr=00000300 inst=0 sreq=1",
                     ibus_req_o, ibus_addr_o, if_inst_o, stallreq_o);
        end
        tick();
        ibus_ack_i = 1'b1;
        settle();
        checks++;
        if ({ibus_addr_o, if_inst_o, stallreq_o} !== {32'h300, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL drop_ack: got addr=%08h inst=%08h sreq=%0b, expected addr=00000300 inst=0 sreq=1",
                     ibus_addr_o, if_inst_o, stallreq_o);
        end
        tick();
        ibus_rdata_i = 32'h0180_0180;
        settle();
        checks++;
        if ({ibus_req_o, ibus_addr_o, if_inst_o} !== {1'b1, 32'h180, 32'h0180_0180}) begin
            errors++;
            $display("FAIL drop_resume: got req=%0b addr=%08h inst=%08h, expected req=1 addr=00000180 inst=01800180",
                     ibus_req_o, ibus_addr_o, if_inst_o);
        end
        tick();
    endtask

    task automatic test_flush_beats_hold();
        jump_to(32'h0000_0500);
        ibus_ack_i = 1'b1; ibus_rdata_i = 32'h7777_0500; stall = 6'b000011;
        flush_i = 1'b1; new_pc_i = 32'h600;
        settle();
        tick();
        flush_i = 1'b0; ibus_ack_i = 1'b0;
        settle();
        checks++;
        if ({ibus_req_o, ibus_addr_o, if_inst_o} !== {1'b1, 32'h600, 32'h0}) begin
            errors++;
            $display("FAIL flush_vs_hold: got req=%0b addr=%08h inst=%08h, expected req=1 addr=00000600 inst=0",
                     ibus_req_o, ibus_addr_o, if_inst_o);
        end
        stall = 6'b0;
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        ibus_ack_i = 1'b1; ibus_rdata_i = 32'h1111_2222;
        settle();
        checks++;
        if ({ibus_addr_o, if_inst_o} !== {32'hFFFF_FFFC, 32'h1111_2222}) begin
            errors++;
            $display("FAIL wrap_last: got addr=%08h inst=%08h, expected addr=fffffffc inst=11112222",
                     ibus_addr_o, if_inst_o);
        end
        tick();
        settle();
        checks++;
        if (ibus_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: got addr=%08h, expected 00000000", ibus_addr_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ibus_ack_i = 1'b0;
        settle();
        tick();
        rst = 1'b1;
        settle();
        checks++;
        if ({ibus_req_o, ibus_addr_o, stallreq_o} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got req=%0b addr=%08h sreq=%0b, expected req=0 addr=0 sreq=0",
                     ibus_req_o, ibus_addr_o, stallreq_o);
        end
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if ({ibus_req_o, ibus_addr_o, stallreq_o} !== {1'b1, 32'hBFC0_0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_restart: got req=%0b addr=%08h sreq=%0b, expected req=1 addr=bfc00000 sreq=1",
                     ibus_req_o, ibus_addr_o, stallreq_o);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_hold();
        test_branch();
        test_flush_drop();
        test_flush_beats_hold();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
